// File: rtl/rom_port_arbiter_if.sv
// Handshake bundle between the fetch/load requesters, the arbiter and the program ROM.
// The arbiter takes the slave view; the core side plus the ROM take the master view.
interface rom_port_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             f_req;
    logic [WIDTH-1:0] f_addr;
    logic             f_gnt;
    logic             f_kill;
    logic             f_rvalid;
    logic [WIDTH-1:0] f_rdata;

    logic             d_req;
    logic [WIDTH-1:0] d_addr;
    logic             d_gnt;
    logic             d_rvalid;
    logic [WIDTH-1:0] d_rdata;
    logic             d_err;

    logic [WIDTH-1:0] rom_addr;
    logic [WIDTH-1:0] rom_data;

    modport slave (
        input  f_req, f_addr, f_kill, d_req, d_addr, rom_data,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_err, rom_addr
    );

    modport master (
        output f_req, f_addr, f_kill, d_req, d_addr, rom_data,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, d_err, rom_addr
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one program-ROM read port between instruction fetch and .rodata loads.
// Loads win by default; a streak counter hands the slot to a waiting fetch periodically.
module rom_port_arbiter #(
    parameter int LENGTH         = 1024,
    parameter int WIDTH          = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    rom_port_arbiter_if.slave  bus
);
    localparam logic [3:0]       BURST_MAX = 4'(MAX_DATA_BURST);
    localparam logic [WIDTH-1:0] LEN_W     = WIDTH'(LENGTH);

    logic [3:0]       streak;
    logic             at_limit;
    logic             d_bad;
    logic [WIDTH-1:0] last_addr_p1;

    logic             f_vld_p1;
    logic             d_vld_p1;
    logic             d_err_p1;
    logic [WIDTH-1:0] f_data_p1;
    logic [WIDTH-1:0] d_data_p1;

    function automatic logic addr_bad(input logic [WIDTH-1:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[WIDTH-1:2]} >= LEN_W);
    endfunction

    // Stage 0: grant decision and ROM address, all combinational
    always_comb begin
        at_limit     = (streak == BURST_MAX);
        bus.d_gnt    = !rst && bus.d_req && !(bus.f_req && at_limit);
        bus.f_gnt    = !rst && bus.f_req && (!bus.d_req || at_limit);
        d_bad        = addr_bad(bus.d_addr);
        bus.rom_addr = last_addr_p1;
        if (bus.d_gnt) begin
            bus.rom_addr = bus.d_addr;
        end else if (bus.f_gnt) begin
            bus.rom_addr = bus.f_addr;
        end
    end

    // Stage 1: capture the ROM word and route it to the winning port
    always_ff @(posedge clk) begin
        if (rst) begin
            f_vld_p1     <= 1'b0;
            d_vld_p1     <= 1'b0;
            d_err_p1     <= 1'b0;
            f_data_p1    <= '0;
            d_data_p1    <= '0;
            last_addr_p1 <= '0;
            streak       <= 4'd0;
        end else begin
            f_vld_p1 <= bus.f_gnt && !bus.f_kill;
            d_vld_p1 <= bus.d_gnt;
            d_err_p1 <= bus.d_gnt && d_bad;
            if (bus.f_gnt) begin
                f_data_p1 <= bus.rom_data;
            end
            if (bus.d_gnt) begin
                d_data_p1 <= d_bad ? '0 : bus.rom_data;
            end
            if (bus.f_gnt || bus.d_gnt) begin
                last_addr_p1 <= bus.rom_addr;
            end
            // Counts only data wins that made a fetch wait
            if (bus.f_gnt || !bus.f_req) begin
                streak <= 4'd0;
            end else if (bus.d_gnt && !at_limit) begin
                streak <= streak + 4'd1;
            end
        end
    end

    assign bus.f_rvalid = f_vld_p1;
    assign bus.f_rdata  = f_data_p1;
    assign bus.d_rvalid = d_vld_p1;
    assign bus.d_err    = d_err_p1;
    assign bus.d_rdata  = d_data_p1;
endmodule
